// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between decode/fetch datapath and the fetch control sequencer.
// master drives the fetch requests (start/stall/branch/instr); slave is the sequencer.
interface fetch_sequencer_if;
    logic        start;
    logic        stall;
    logic        PCSrc;
    logic [31:0] instr;
    logic        pc_en;
    logic        pc_sel;
    logic        ifid_en;
    logic        ifid_flush;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;

    modport master (
        output start, stall, PCSrc, instr,
        input  pc_en, pc_sel, ifid_en, ifid_flush, fetch_valid, halted,
               fetch_count, redirect_count
    );

    modport slave (
        input  start, stall, PCSrc, instr,
        output pc_en, pc_sel, ifid_en, ifid_flush, fetch_valid, halted,
               fetch_count, redirect_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: PC enable, branch mux select and IF/ID enable/flush,
// with bounded bubble after taken branches, halt on a sentinel word and debug counters.
module fetch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, STALL, FLUSH, HALT} state_t;

    localparam logic [3:0] BUB_LOAD = 4'(FLUSH_CYCLES - 1);
    // A single-cycle bubble is fully covered by the redirect cycle itself.
    localparam state_t AFTER_BRANCH = (FLUSH_CYCLES == 1) ? FETCH : FLUSH;

    state_t      state, state_nxt;
    logic [3:0]  bub, bub_nxt;
    logic [31:0] fetch_cnt;
    logic [15:0] redirect_cnt;
    logic        pc_en, pc_sel, ifid_en, ifid_flush, redirect;

    always_comb begin
        state_nxt  = state;
        bub_nxt    = bub;
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        redirect   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = FETCH;
            FETCH, STALL: begin
                if (bus.PCSrc) begin
                    redirect   = 1'b1;
                    pc_en      = 1'b1;
                    pc_sel     = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    bub_nxt    = BUB_LOAD;
                    state_nxt  = AFTER_BRANCH;
                end else if (bus.instr == HALT_WORD) begin
                    state_nxt = HALT;
                end else if (bus.stall) begin
                    state_nxt = STALL;
                end else if (state == FETCH) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end else begin
                    // held instruction is accepted on the following FETCH cycle
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                if (bus.PCSrc) begin
                    redirect = 1'b1;
                    pc_sel   = 1'b1;
                    bub_nxt  = BUB_LOAD;
                end else if (bub <= 4'd1) begin
                    bub_nxt   = 4'd0;
                    state_nxt = FETCH;
                end else begin
                    bub_nxt = bub - 4'd1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bub             <= 4'd0;
            bus.fetch_valid <= 1'b0;
            bus.halted      <= 1'b0;
            fetch_cnt       <= 32'd0;
            redirect_cnt    <= 16'd0;
        end else begin
            state           <= state_nxt;
            bub             <= bub_nxt;
            bus.fetch_valid <= (state_nxt == FETCH);
            bus.halted      <= (state_nxt == HALT);
            if (ifid_en && !ifid_flush && fetch_cnt != 32'hFFFF_FFFF)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect && redirect_cnt != 16'hFFFF)
                redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

    assign bus.pc_en          = pc_en;
    assign bus.pc_sel         = pc_sel;
    assign bus.ifid_en        = ifid_en;
    assign bus.ifid_flush     = ifid_flush;
    assign bus.fetch_count    = fetch_cnt;
    assign bus.redirect_count = redirect_cnt;
endmodule
